n_bit_deserializer: RTL and testbench

- Serial-to-parallel receiver: the opposite end of the team's parallel-load/serial-out shift register.
- Accepts one serial bit per qualified clock and assembles n-bit words, MSB-first or LSB-first.
- Presents each completed word on a registered parallel output with a valid/ready handshake.
- One-word output buffer; sticky overrun flag; start-of-word input to resynchronise framing.

---
 rtl/n_bit_deserializer_if.sv | 25 ++
 rtl/n_bit_deserializer.sv | 134 +++++++++++++
 tb/tb_n_bit_deserializer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/n_bit_deserializer_if.sv
// Handshake bundle for the serial-to-parallel receiver.
// The master side drives serial bits and consumes words; the slave side is the receiver.
interface n_bit_deserializer_if #(
   parameter int n = 4
);
   logic         dSerial;   // serial data bit
   logic         sValid;    // dSerial is valid this cycle
   logic         sStart;    // with sValid: this bit is bit 0 of a new word
   logic         shiftL;    // 1 = MSB-first, 0 = LSB-first (sampled on first bit)
   logic [n-1:0] Q;         // completed parallel word
   logic         qValid;    // Q holds an unread word
   logic         qReady;    // consumer accepts Q this cycle
   logic         overrun;   // sticky: a completed word was dropped
   logic         ovrClr;    // synchronous clear of overrun

   modport master (
      output dSerial, sValid, sStart, shiftL, qReady, ovrClr,
      input  Q, qValid, overrun
   );

   modport slave (
      input  dSerial, sValid, sStart, shiftL, qReady, ovrClr,
      output Q, qValid, overrun
   );
endinterface

// File: rtl/n_bit_deserializer.sv
// Serial-to-parallel receiver: collects one bit per qualified clock into an
// n-bit word (MSB-first or LSB-first), then hands the word over through a
// single registered buffer with valid/ready. A word that completes while the
// buffer is still occupied and not being read is dropped and flagged in a
// sticky overrun bit. sStart resynchronises framing to a new word.
module n_bit_deserializer #(
   parameter int n = 4
) (
   input  logic                  clk,
   input  logic                  clr,
   n_bit_deserializer_if.slave   des_if
);

   localparam int CNT_W = (n > 2) ? $clog2(n) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(n - 1);

   // Assembly state
   logic [n-1:0]     sr_q,  sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;

   // Output buffer state
   logic [n-1:0]     q_q,      q_d;
   logic             qvalid_q, qvalid_d;
   logic             ovr_q,    ovr_d;

   // Decoded per-cycle conditions
   logic             first_s;
   logic             dir_s;
   logic [n-1:0]     shifted_s;
   logic             complete_s;
   logic             read_s;
   logic             accept_s;

   // Decode the current bit: effective direction, post-shift word, completion and buffer status
   always_comb begin
      first_s    = des_if.sStart | (cnt_q == CNT_ZERO);
      // The first bit of a word uses the live shiftL; later bits use the latched direction
      dir_s      = first_s ? des_if.shiftL : dir_q;
      if (dir_s) begin
         shifted_s = {sr_q[n-2:0], des_if.dSerial};
      end else begin
         shifted_s = {des_if.dSerial, sr_q[n-1:1]};
      end
      // sStart always makes this bit 0 of a new word, so it can never complete one
      complete_s = des_if.sValid & ~des_if.sStart & (cnt_q == CNT_LAST);
      read_s     = qvalid_q & des_if.qReady;
      // Buffer can take a new word if empty or being emptied this very cycle
      accept_s   = ~qvalid_q | des_if.qReady;
   end

   // Next-state for the shift register, bit counter and latched direction
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (des_if.sValid) begin
         sr_d  = shifted_s;
         dir_d = dir_s;
         if (des_if.sStart) begin
            // Partial word is abandoned silently; this bit counts as bit 0
            cnt_d = CNT_ONE;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_ZERO;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         sr_d  = sr_q;
         cnt_d = cnt_q;
         dir_d = dir_q;
      end
   end

   // Next-state for the output buffer and the sticky overrun flag
   always_comb begin
      q_d      = q_q;
      qvalid_d = qvalid_q;
      ovr_d    = ovr_q;

      if (complete_s && accept_s) begin
         // Covers the simultaneous read+write case: no bubble between words
         q_d      = shifted_s;
         qvalid_d = 1'b1;
      end else if (read_s) begin
         // Q keeps its last value after being read; only the valid drops
         qvalid_d = 1'b0;
      end else begin
         qvalid_d = qvalid_q;
      end

      // A new drop outranks a clear request in the same cycle
      if (complete_s && !accept_s) begin
         ovr_d = 1'b1;
      end else if (des_if.ovrClr) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Assembly registers; clr discards any partial word immediately
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sr_q  <= '0;
         cnt_q <= CNT_ZERO;
         dir_q <= 1'b1;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         dir_q <= dir_d;
      end
   end

   // Output buffer registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         q_q      <= '0;
         qvalid_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         q_q      <= q_d;
         qvalid_q <= qvalid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign des_if.Q       = q_q;
   assign des_if.qValid  = qvalid_q;
   assign des_if.overrun = ovr_q;

endmodule

// File: tb/tb_n_bit_deserializer.sv
// Bench for n_bit_deserializer: a 4-bit instance driven through a scoreboard of
// expected words, plus a 2-bit instance for the minimum-width boundary.
module tb_n_bit_deserializer;

   localparam int N = 4;

   logic clk = 1'b0;
   logic clr;

   always #5 clk = ~clk;

   n_bit_deserializer_if #(.n(N)) bus ();
   n_bit_deserializer_if #(.n(2)) bus2 ();

   n_bit_deserializer #(.n(N)) dut (
      .clk    (clk),
      .clr    (clr),
      .des_if (bus)
   );

   n_bit_deserializer #(.n(2)) dut2 (
      .clk    (clk),
      .clr    (clr),
      .des_if (bus2)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [N-1:0] exp_q[$];

   // One clock; afterwards, any freshly loaded word is popped from the scoreboard and compared
   task automatic cyc();
      logic was_v;
      logic was_r;
      logic [N-1:0] e;
      was_v = bus.qValid;
      was_r = bus.qValid & bus.qReady;
      @(posedge clk);
      #1;
      if (bus.qValid && (!was_v || was_r)) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_word: got Q=%h, required no word", bus.Q);
         end else begin
            e = exp_q.pop_front();
            if (bus.Q !== e) begin
               n_fail++;
               $display("FAIL word: got Q=%h, required %h", bus.Q, e);
            end
         end
      end
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc();
   endtask

   task automatic send(input logic d, input logic st, input logic sl);
      bus.dSerial = d;
      bus.sStart  = st;
      bus.shiftL  = sl;
      bus.sValid  = 1'b1;
      cyc();
      bus.sValid  = 1'b0;
      bus.sStart  = 1'b0;
   endtask

   task automatic send_word(input logic [N-1:0] w, input logic st);
      for (int i = N - 1; i >= 0; i--) send(w[i], st && (i == N - 1), 1'b1);
   endtask

   task automatic check_empty(input string name);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_missing_words: got %0d pending, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      clr = 1'b1;
      #12;
      n_checks++;
      if ({bus.Q, bus.qValid, bus.overrun} !== {4'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: got Q=%h qValid=%b overrun=%b, required 0 0 0", bus.Q, bus.qValid, bus.overrun);
      end
      clr = 1'b0;
   endtask

   task automatic test_msb_first();
      bus.qReady = 1'b1;
      exp_q.push_back(4'b1011);
      send(1'b1, 1'b1, 1'b1);
      send(1'b0, 1'b0, 1'b1);
      send(1'b1, 1'b0, 1'b1);
      send(1'b1, 1'b0, 1'b1);
      n_checks++;
      if ({bus.qValid, bus.overrun} !== 2'b10) begin
         n_fail++;
         $display("FAIL msb_valid: got qValid=%b overrun=%b, required 1 0", bus.qValid, bus.overrun);
      end
      cyc();
      n_checks++;
      if (bus.qValid !== 1'b0) begin
         n_fail++;
         $display("FAIL msb_one_cycle: got qValid=%b, required 0", bus.qValid);
      end
      check_empty("msb");
   endtask

   task automatic test_lsb_gaps();
      bus.qReady = 1'b1;
      exp_q.push_back(4'b1101);
      send(1'b1, 1'b0, 1'b0);
      idle(1);
      send(1'b0, 1'b0, 1'b1);
      idle(2);
      send(1'b1, 1'b0, 1'b1);
      idle(1);
      send(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (bus.qValid !== 1'b1) begin
         n_fail++;
         $display("FAIL lsb_valid: got qValid=%b, required 1", bus.qValid);
      end
      cyc();
      check_empty("lsb");
   endtask

   task automatic test_back_to_back();
      bus.qReady = 1'b1;
      exp_q.push_back(4'hA);
      exp_q.push_back(4'h5);
      send_word(4'hA, 1'b1);
      send_word(4'h5, 1'b0);
      n_checks++;
      if ({bus.qValid, bus.overrun} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_stream: got qValid=%b overrun=%b, required 1 0", bus.qValid, bus.overrun);
      end
      cyc();
      // Read and new load on the same edge: no drop, no bubble
      bus.qReady = 1'b0;
      exp_q.push_back(4'h9);
      exp_q.push_back(4'h6);
      send_word(4'h9, 1'b0);
      send(1'b0, 1'b0, 1'b1);
      send(1'b1, 1'b0, 1'b1);
      send(1'b1, 1'b0, 1'b1);
      bus.qReady = 1'b1;
      send(1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({bus.qValid, bus.overrun} !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_same_edge: got qValid=%b overrun=%b, required 1 0", bus.qValid, bus.overrun);
      end
      cyc();
      n_checks++;
      if (bus.qValid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: got qValid=%b, required 0", bus.qValid);
      end
      check_empty("b2b");
   endtask

   task automatic test_overrun();
      bus.qReady = 1'b0;
      exp_q.push_back(4'h3);
      send_word(4'h3, 1'b0);
      send_word(4'hC, 1'b0);
      n_checks++;
      if ({bus.Q, bus.qValid, bus.overrun} !== {4'h3, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL ovr_set: got Q=%h qValid=%b overrun=%b, required 3 1 1", bus.Q, bus.qValid, bus.overrun);
      end
      bus.ovrClr = 1'b1;
      cyc();
      bus.ovrClr = 1'b0;
      n_checks++;
      if (bus.overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_clear: got overrun=%b, required 0", bus.overrun);
      end
      bus.qReady = 1'b1;
      cyc();
      n_checks++;
      if (bus.qValid !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_read: got qValid=%b, required 0", bus.qValid);
      end
      // Clear request on the same edge as a fresh drop: the drop wins
      bus.qReady = 1'b0;
      exp_q.push_back(4'h1);
      send_word(4'h1, 1'b0);
      send(1'b0, 1'b0, 1'b1);
      send(1'b0, 1'b0, 1'b1);
      send(1'b1, 1'b0, 1'b1);
      bus.ovrClr = 1'b1;
      send(1'b0, 1'b0, 1'b1);
      bus.ovrClr = 1'b0;
      n_checks++;
      if ({bus.Q, bus.overrun} !== {4'h1, 1'b1}) begin
         n_fail++;
         $display("FAIL ovr_set_wins: got Q=%h overrun=%b, required 1 1", bus.Q, bus.overrun);
      end
      bus.ovrClr = 1'b1;
      bus.qReady = 1'b1;
      cyc();
      bus.ovrClr = 1'b0;
      n_checks++;
      if ({bus.qValid, bus.overrun} !== 2'b00) begin
         n_fail++;
         $display("FAIL ovr_final: got qValid=%b overrun=%b, required 0 0", bus.qValid, bus.overrun);
      end
      check_empty("ovr");
   endtask

   task automatic test_resync();
      bus.qReady = 1'b1;
      exp_q.push_back(4'b0110);
      send(1'b1, 1'b1, 1'b1);
      send(1'b1, 1'b0, 1'b1);
      send_word(4'b0110, 1'b1);
      n_checks++;
      if (bus.qValid !== 1'b1) begin
         n_fail++;
         $display("FAIL resync_valid: got qValid=%b, required 1", bus.qValid);
      end
      idle(2);
      check_empty("resync");
   endtask

   task automatic test_async_reset();
      bus.qReady = 1'b0;
      exp_q.push_back(4'h7);
      send_word(4'h7, 1'b0);
      send_word(4'h8, 1'b0);
      send(1'b1, 1'b0, 1'b1);
      send(1'b0, 1'b0, 1'b1);
      send(1'b1, 1'b0, 1'b1);
      #2 clr = 1'b1;
      #1;
      n_checks++;
      if ({bus.Q, bus.qValid, bus.overrun} !== {4'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset: got Q=%h qValid=%b overrun=%b, required 0 0 0", bus.Q, bus.qValid, bus.overrun);
      end
      #1 clr = 1'b0;
      bus.qReady = 1'b1;
      exp_q.push_back(4'hF);
      for (int i = 0; i < N; i++) send(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (bus.qValid !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_valid: got qValid=%b, required 1", bus.qValid);
      end
      cyc();
      check_empty("async");
   endtask

   task automatic send2(input logic d, input logic st);
      bus2.dSerial = d;
      bus2.sStart  = st;
      bus2.sValid  = 1'b1;
      @(posedge clk);
      #1;
      bus2.sValid  = 1'b0;
      bus2.sStart  = 1'b0;
   endtask

   task automatic test_n2();
      bus2.qReady = 1'b1;
      bus2.shiftL = 1'b1;
      send2(1'b1, 1'b1);
      n_checks++;
      if (bus2.qValid !== 1'b0) begin
         n_fail++;
         $display("FAIL n2_first_bit: got qValid=%b, required 0", bus2.qValid);
      end
      send2(1'b0, 1'b0);
      n_checks++;
      if ({bus2.Q, bus2.qValid} !== {2'b10, 1'b1}) begin
         n_fail++;
         $display("FAIL n2_word: got Q=%b qValid=%b, required 10 1", bus2.Q, bus2.qValid);
      end
      send2(1'b1, 1'b0);
      send2(1'b0, 1'b1);
      n_checks++;
      if (bus2.qValid !== 1'b0) begin
         n_fail++;
         $display("FAIL n2_restart: got qValid=%b, required 0", bus2.qValid);
      end
      send2(1'b1, 1'b0);
      n_checks++;
      if ({bus2.Q, bus2.qValid, bus2.overrun} !== {2'b01, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL n2_after_restart: got Q=%b qValid=%b overrun=%b, required 01 1 0", bus2.Q, bus2.qValid, bus2.overrun);
      end
   endtask

   initial begin
      clr          = 1'b1;
      bus.dSerial  = 1'b0;
      bus.sValid   = 1'b0;
      bus.sStart   = 1'b0;
      bus.shiftL   = 1'b1;
      bus.qReady   = 1'b0;
      bus.ovrClr   = 1'b0;
      bus2.dSerial = 1'b0;
      bus2.sValid  = 1'b0;
      bus2.sStart  = 1'b0;
      bus2.shiftL  = 1'b1;
      bus2.qReady  = 1'b0;
      bus2.ovrClr  = 1'b0;

      test_reset();
      test_msb_first();
      test_lsb_gaps();
      test_back_to_back();
      test_overrun();
      test_resync();
      test_async_reset();
      test_n2();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
